mem_responder: RTL

- Word-addressed memory target that serves the load/store/fetch requests issued by the multicycle MIPS core. It is the responder end of the core's request/response memory interface.
- Accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states.
- Returns read data or write completion over a second valid/ready handshake.
- Flags misaligned and out-of-range accesses.

---
 rtl/mem_responder_if.sv | 22 ++
 rtl/mem_responder.sv | 96 +++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Request/response channel between the core (master) and a memory target (slave).
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory target: one outstanding request, programmable wait
// states, error flag for misaligned or out-of-range byte addresses.
module mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus,
    output logic            busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [3:0]            cnt;
    mem_req_t              req_q;
    mem_req_t              cur;
    logic [31:0]           mem [DEPTH];
    logic                  accept;
    logic                  to_resp;
    logic                  cur_err;
    logic [DEPTH_LOG2-1:0] cur_idx;

    assign accept = (state == IDLE) && bus.req_ready && bus.req_valid;

    // With zero wait states the response is formed on the accept edge itself,
    // so the live request fields stand in for the latched copy.
    always_comb begin
        cur = req_q;
        if (state == IDLE)
            cur = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
    end

    assign cur_err = (cur.addr[1:0] != 2'b00) || (cur.addr[31:DEPTH_LOG2+2] != '0);
    assign cur_idx = cur.addr[DEPTH_LOG2+1:2];
    assign to_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd1));

    // Writes commit only on entry to RESP, so a reset during WAIT drops them.
    always_ff @(posedge clk) begin
        if (to_resp && cur.we && !cur_err)
            mem[cur_idx] <= cur.wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            req_q          <= '0;
            busy           <= 1'b0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (accept) begin
                        req_q         <= cur;
                        cnt           <= 4'(WAIT_CYCLES);
                        busy          <= 1'b1;
                        bus.req_ready <= 1'b0;
                        state         <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: cnt <= cnt - 4'd1;
                RESP: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        bus.resp_valid <= 1'b0;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= 32'd0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (to_resp) begin
                state          <= RESP;
                bus.resp_valid <= 1'b1;
                bus.resp_err   <= cur_err;
                bus.resp_rdata <= (cur.we || cur_err) ? 32'd0 : mem[cur_idx];
            end
        end
    end
endmodule
